booth_seq_mult: RTL and testbench
=================================

Name: booth_seq_mult

Overview:
- Sequential radix-2 Booth multiplier for signed two's-complement operands; the next stage of the Multiplier_P datapath.
- Reuses the add/sub arithmetic already verified in the lab: add when the Booth pair is 01, subtract when it is 10, arithmetic shift right every step.
- Produces one 2*WIDTH-bit signed product per start request, with a single-cycle done pulse.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits. Legal range 2..16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand, signed two's complement.
- b  input  WIDTH  multiplier, signed two's complement.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  signed result; holds until the next completion.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal registers cleared.
  - Applies immediately mid-operation; the in-flight multiply is abandoned and no done is issued.
- Internal registers:
  - M: WIDTH+1 bits, a sign-extended.
  - ACC: WIDTH+1 bits.
  - Q: WIDTH bits.
  - Q_1: 1 bit.
  - CNT: counts WIDTH down to 0.
- IDLE:
  - busy=0.
  - start=1 at an edge: M<=sext(a), ACC<=0, Q<=b, Q_1<=0, CNT<=WIDTH, go to RUN.
  - a and b are captured only at this edge; later changes have no effect.
- RUN (busy=1), one Booth step per edge:
  - {Q[0],Q_1}=01: T=ACC+M.
  - {Q[0],Q_1}=10: T=ACC-M, computed as ACC+~M+1.
  - Otherwise: T=ACC.
  - Then {ACC,Q,Q_1} <= arithmetic right shift of {T,Q,Q_1} by 1, with T's MSB replicated.
  - Arithmetic is mod 2^(WIDTH+1); the extra ACC bit prevents overflow for a = -2^(WIDTH-1).
  - CNT decrements each step.
  - On the step where CNT goes 1->0: product <= {ACC[WIDTH-1:0],Q} (post-shift values), go to DONE.
- DONE:
  - done=1 and busy=0 for exactly this one cycle.
  - Next edge goes to IDLE unconditionally.
  - start in DONE is ignored.
- Latency:
  - start accepted at edge E; done high in the cycle following edge E+WIDTH.
  - product valid from that cycle onward.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy or in DONE is ignored, not queued.
- All outputs are registered; no combinational path from inputs to outputs.
- product width rule: the full range -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2) fits in 2*WIDTH signed bits, so no saturation is needed.
- Zero operands still take the full WIDTH steps; no early termination.

Test Plan:
- WIDTH=4, a=3, b=5, start for 1 cycle -> done exactly 5 cycles after the start edge, product=8'h0F; busy high for the 4 cycles in between.
- a=-8 (4'b1000), b=-8 -> product=8'h40 (+64); then a=7, b=-8 -> product=8'hC8 (-56).
- a=-1, b=1 -> product=8'hFF; a=0, b=-5 -> product=8'h00, done still 5 cycles after start.
- Start a=2, b=3; toggle a/b and pulse start during RUN -> product=8'h06, a single done pulse, no second operation begun.
- Start a=5, b=5; assert rst_n=0 on the 2nd RUN cycle -> next cycle busy=0, done=0, product=0; no done afterwards; a fresh start a=-3, b=4 -> product=8'hF4.
- Back-to-back: assert start again in the cycle after done -> accepted, second product correct; a start held high continuously produces one operation every WIDTH+2 cycles.

Source files
------------

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one signed WIDTH x WIDTH product every
// WIDTH+2 cycles, with a busy flag and a single-cycle done pulse.
module booth_seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       sum;

  // NOTE: always_comb uses blocking '=' with a default for every signal first,
  // so no latch is inferred and later statements see the updated values.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    sum       = acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = {a[WIDTH-1], a};
          acc_d   = '0;
          q_d     = b;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The extra ACC bit keeps ACC-M in range when a is the most negative value.
        case ({q_q[0], q1_q})
          2'b01:   sum = acc_q + m_q;
          2'b10:   sum = acc_q + ~m_q + {{WIDTH{1'b0}}, 1'b1};
          default: sum = acc_q;
        endcase
        acc_d = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_d = {acc_d[WIDTH-1:0], q_d};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and sequential
  // state is only ever written with non-blocking '<='.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult (WIDTH=4): products, latency, ignored
// starts, mid-run reset and back-to-back / continuous operation.
module tb_booth_seq_mult;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int n_checks = 0;
  int n_errors = 0;

  booth_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called just after the accepting edge; returns edges until done (-1 on timeout)
  // and the number of cycles busy was seen high before done.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = busy ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic do_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input logic [7:0] exp);
    int lat, bcnt;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    wait_done(lat, bcnt);
    check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(WIDTH));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_product"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int lat, bcnt, ndone, ncyc;
    int dt[3];

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("3x5", 4'h3, 4'h5, 8'h0F);
    @(posedge clk); #1;
    do_op("m8xm8", 4'h8, 4'h8, 8'h40);
    @(posedge clk); #1;
    do_op("7xm8", 4'h7, 4'h8, 8'hC8);
    @(posedge clk); #1;
    do_op("m1x1", 4'hF, 4'h1, 8'hFF);
    @(posedge clk); #1;
    do_op("0xm5", 4'h0, 4'hB, 8'h00);
    @(posedge clk); #1;

    // Operand changes and start pulses during RUN must be ignored.
    a = 4'h2; b = 4'h3; start = 1'b1;
    @(posedge clk); #1;
    a = 4'h7; b = 4'hF;
    wait_done(lat, bcnt);
    start = 1'b0;
    check("toggle_latency", 32'(lat), 32'(WIDTH));
    check("toggle_product", 32'(product), 32'h06);
    @(posedge clk); #1;
    check("toggle_idle_busy", 32'(busy), 32'd0);
    check("toggle_idle_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("toggle_no_restart", 32'(busy), 32'd0);
    check("toggle_product_hold", 32'(product), 32'h06);

    // Reset during the second RUN cycle abandons the multiply.
    a = 4'h5; b = 4'h5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    do_op("m3x4", 4'hD, 4'h4, 8'hF4);

    // Start asserted in the cycle right after done.
    @(posedge clk); #1;
    do_op("b2b", 4'h9, 4'h5, 8'hDD);

    // Start held high: one operation every WIDTH+2 cycles.
    a = 4'hC; b = 4'hD; start = 1'b1;
    ndone = 0;
    ncyc  = 0;
    for (int i = 0; i < 40 && ndone < 3; i++) begin
      @(posedge clk); #1;
      ncyc++;
      if (done) begin
        dt[ndone] = ncyc;
        check($sformatf("cont_product%0d", ndone), 32'(product), 32'h0C);
        ndone++;
      end
    end
    start = 1'b0;
    check("cont_pulses", 32'(ndone), 32'd3);
    if (ndone == 3) begin
      check("cont_spacing1", 32'(dt[1] - dt[0]), 32'(WIDTH + 2));
      check("cont_spacing2", 32'(dt[2] - dt[1]), 32'(WIDTH + 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
